// File: rtl/pcm2pdm_modulator_pkg.sv
// Shared playback definitions for the PCM-to-PDM modulator: default widths,
// the offset-binary constant and a bundled configuration record.
package pcm2pdm_modulator_pkg;

  localparam int SAMPLE_WIDTH  = 16;
  localparam int DIVISOR_WIDTH = 7;

  // Flips the sign bit so a signed sample becomes an unsigned ones-density target
  localparam logic [15:0] PCM_OFFSET = 16'h8000;

  typedef struct packed {
    logic [DIVISOR_WIDTH-1:0] divisor;
    logic [DIVISOR_WIDTH-1:0] rate;
    logic [3:0]               attenuation;
  } pdm_cfg_t;

endpackage

// File: rtl/pcm2pdm_modulator_pdm_clock_generator.sv
// PDM clock divider; tick marks the cycle whose closing edge drives pdm_clk low.
module pdm_clock_generator #(
  parameter int DIVISOR_WIDTH = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [DIVISOR_WIDTH-1:0] divisor_i,
  output logic                     pdm_clk_o,
  output logic                     tick_o
);

  logic [DIVISOR_WIDTH-1:0] count;
  logic                     wrap;

  // Using >= lets a freshly lowered divisor force a toggle on the next cycle
  assign wrap   = count >= divisor_i;
  assign tick_o = en_i && wrap && pdm_clk_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count     <= '0;
      pdm_clk_o <= 1'b0;
    end else if (!en_i) begin
      count     <= '0;
      pdm_clk_o <= 1'b0;
    end else if (wrap) begin
      count     <= '0;
      pdm_clk_o <= ~pdm_clk_o;
    end else begin
      count <= count + DIVISOR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pcm2pdm_modulator.sv
// First-order sigma-delta PCM to PDM modulator with a one-entry sample buffer
// and an underrun flag raised when a sample boundary finds nothing to play.
module pcm2pdm_modulator #(
  parameter int SAMPLE_WIDTH  = pcm2pdm_modulator_pkg::SAMPLE_WIDTH,
  parameter int DIVISOR_WIDTH = pcm2pdm_modulator_pkg::DIVISOR_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clk_en_i,
  input  logic [DIVISOR_WIDTH-1:0] clock_divisor_i,
  input  logic [DIVISOR_WIDTH-1:0] oversample_rate_i,
  input  logic [3:0]               attenuation_i,
  input  logic [SAMPLE_WIDTH-1:0]  pcm_sample_i,
  input  logic                     pcm_valid_i,
  output logic                     pcm_ready_o,
  output logic                     pdm_clk_o,
  output logic                     pdm_data_o,
  output logic                     underrun_o
);
  import pcm2pdm_modulator_pkg::*;

  pdm_cfg_t                        cfg;
  logic                            tick;
  logic                            boundary;
  logic                            starved;
  logic                            buf_valid;
  logic signed [SAMPLE_WIDTH-1:0]  buf_data;
  logic signed [SAMPLE_WIDTH-1:0]  current;
  logic signed [SAMPLE_WIDTH-1:0]  load_sample;
  logic signed [SAMPLE_WIDTH-1:0]  active;
  logic [DIVISOR_WIDTH-1:0]        bit_cnt;
  logic [DIVISOR_WIDTH-1:0]        last_bit;
  logic [15:0]                     acc;
  logic [15:0]                     u;
  logic [16:0]                     sum;

  assign cfg = '{divisor: clock_divisor_i, rate: oversample_rate_i,
                 attenuation: attenuation_i};

  pdm_clock_generator #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_clock_generator (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (clk_en_i),
    .divisor_i (cfg.divisor),
    .pdm_clk_o (pdm_clk_o),
    .tick_o    (tick)
  );

  assign pcm_ready_o = !buf_valid;
  assign last_bit    = (cfg.rate == '0) ? '0 : cfg.rate - DIVISOR_WIDTH'(1);
  assign boundary    = tick && (bit_cnt == '0);
  assign starved     = !buf_valid && !pcm_valid_i;

  // A boundary tick plays the freshly loaded sample, not the previous one
  always_comb begin
    load_sample = '0;
    if (buf_valid)        load_sample = buf_data;
    else if (pcm_valid_i) load_sample = pcm_sample_i;
    active = boundary ? load_sample : current;
    u      = 16'(active >>> cfg.attenuation) ^ PCM_OFFSET;
    sum    = {1'b0, acc} + {1'b0, u};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      buf_valid  <= 1'b0;
      buf_data   <= '0;
      current    <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      pdm_data_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      if (!clk_en_i) begin
        current    <= '0;
        bit_cnt    <= '0;
        acc        <= '0;
        pdm_data_o <= 1'b0;
      end else if (tick) begin
        current    <= active;
        acc        <= sum[15:0];
        pdm_data_o <= sum[16];
        bit_cnt    <= (bit_cnt >= last_bit) ? '0 : bit_cnt + DIVISOR_WIDTH'(1);
        if (boundary && starved) underrun_o <= 1'b1;
      end
      // A boundary that bypasses the empty buffer consumes the offered sample itself
      if (boundary && buf_valid) begin
        buf_valid <= 1'b0;
      end else if (pcm_valid_i && !buf_valid && !boundary) begin
        buf_valid <= 1'b1;
        buf_data  <= pcm_sample_i;
      end
    end
  end

endmodule

// File: tb/tb_pcm2pdm_modulator.sv
// Self-checking bench: an arithmetic reference model checked every cycle plus
// hand-computed literal expectations for each directed scenario.
module tb_pcm2pdm_modulator;

  localparam int SW = 16;
  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b0;
  logic [DW-1:0] div = '0;
  logic [DW-1:0] rate = 7'd1;
  logic [3:0]    att = '0;
  logic [SW-1:0] sample = '0;
  logic          valid = 1'b0;
  logic          pcm_ready, pdm_clk, pdm_data, underrun;

  always #5 clk = ~clk;

  pcm2pdm_modulator #(.SAMPLE_WIDTH(SW), .DIVISOR_WIDTH(DW)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .clk_en_i          (clk_en),
    .clock_divisor_i   (div),
    .oversample_rate_i (rate),
    .attenuation_i     (att),
    .pcm_sample_i      (sample),
    .pcm_valid_i       (valid),
    .pcm_ready_o       (pcm_ready),
    .pdm_clk_o         (pdm_clk),
    .pdm_data_o        (pdm_data),
    .underrun_o        (underrun)
  );

  int errors = 0;
  int checks = 0;

  // Model state: enabled-edge count, tick count, accumulator, buffer
  int          m_k = 0, m_div = 1, m_n = 1, m_ticks = 0, m_acc = 0, m_sv = 0, m_u = 0;
  bit          m_clk = 0, m_data = 0, m_under = 0, m_tick = 0;
  bit          m_full = 0, m_bypass = 0, m_ready = 1;
  logic [15:0] m_buf = '0, m_cur = '0;

  int tick_cnt = 0, ones_cnt = 0, under_cnt = 0;
  bit bits [0:16383];

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input bit en, input int d, input int r, input int a,
                                input int s, input bit v);
    clk_en = en;
    div    = DW'(d);
    rate   = DW'(r);
    att    = 4'(a);
    sample = SW'(s);
    valid  = v;
  endtask

  task automatic reset_dut();
    clk_en = 1'b0;
    valid  = 1'b0;
    rst    = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
  endtask

  task automatic model_step();
    m_tick   = 0;
    m_under  = 0;
    m_bypass = 0;
    if (rst) begin
      m_k = 0; m_ticks = 0; m_acc = 0; m_clk = 0; m_data = 0;
      m_full = 0; m_buf = '0; m_cur = '0;
      return;
    end
    m_ready = !m_full;
    if (clk_en) begin
      m_div = int'(div) + 1;
      m_n   = (rate == 0) ? 1 : int'(rate);
      m_k++;
      m_clk  = ((m_k / m_div) % 2) == 1;
      m_tick = (m_k % m_div == 0) && !m_clk;
      if (m_tick) begin
        if (m_ticks % m_n == 0) begin
          if (m_full) begin
            m_cur  = m_buf;
            m_full = 0;
          end else if (valid) begin
            m_cur    = sample;
            m_bypass = 1;
          end else begin
            m_cur   = '0;
            m_under = 1;
          end
        end
        m_sv   = int'($signed(m_cur)) >>> att;
        m_u    = (m_sv & 32'hFFFF) ^ 32'h8000;
        m_acc  = m_acc + m_u;
        m_data = m_acc >= 65536;
        m_acc  = m_acc % 65536;
        m_ticks++;
      end
    end else begin
      m_k = 0; m_ticks = 0; m_acc = 0; m_clk = 0; m_data = 0; m_cur = '0;
    end
    if (valid && m_ready && !m_bypass) begin
      m_full = 1;
      m_buf  = sample;
    end
  endtask

  task automatic compare_step();
    if (rst) return;
    check_output("pdm_clk", pdm_clk, m_clk);
    check_output("pdm_data", pdm_data, m_data);
    check_output("underrun", underrun, m_under);
    check_output("pcm_ready", pcm_ready, !m_full);
    if (m_tick) begin
      if (tick_cnt < 16384) bits[tick_cnt] = pdm_data;
      ones_cnt += int'(pdm_data);
      tick_cnt++;
    end
    under_cnt += int'(underrun);
  endtask

  initial begin
    fork
      forever begin
        @(posedge clk or posedge rst);
        model_step();
      end
      forever begin
        @(negedge clk);
        compare_step();
      end
      begin : stimulus
        int first_rise, second_rise, bad_changes, i0, t0, o0, u0;
        bit prev_clk, prev_data;

        step(3);
        check_output("reset pdm_clk", pdm_clk, 0);
        check_output("reset pdm_data", pdm_data, 0);
        check_output("reset pcm_ready", pcm_ready, 1);
        check_output("reset underrun", underrun, 0);
        rst = 1'b0;
        step(1);

        // Divisor 1: period 4, first rise two cycles after enable
        apply_stimulus(1, 1, 1, 0, 'h4000, 1);
        first_rise = -1; second_rise = -1; bad_changes = 0;
        prev_clk = 0; prev_data = 0;
        for (int i = 1; i <= 40; i++) begin
          step(1);
          if (pdm_clk && !prev_clk) begin
            if (first_rise < 0) first_rise = i;
            else if (second_rise < 0) second_rise = i;
          end
          if (pdm_data != prev_data && !(prev_clk && !pdm_clk)) bad_changes++;
          prev_clk = pdm_clk;
          prev_data = pdm_data;
        end
        check_output("first rise cycle", first_rise, 2);
        check_output("second rise cycle", second_rise, 6);
        check_output("data change off fall", bad_changes, 0);
        reset_dut();

        // Rate 4, zero sample: bits alternate 0,1
        apply_stimulus(1, 0, 4, 0, 'h0000, 1);
        t0 = tick_cnt; o0 = ones_cnt; u0 = under_cnt;
        step(40);
        for (int j = 0; j < 4; j++) check_output("zero sample bit", bits[t0 + j], j % 2);
        check_output("zero sample ticks", tick_cnt - t0, 20);
        check_output("zero sample ones", ones_cnt - o0, 10);
        check_output("zero sample underruns", under_cnt - u0, 0);
        reset_dut();

        // Most negative sample with rate 0 (acts as 1): never a one
        apply_stimulus(1, 0, 0, 0, 'h8000, 1);
        o0 = ones_cnt;
        step(20);
        check_output("min sample ones", ones_cnt - o0, 0);
        reset_dut();

        // Most positive sample: first bit 0, then ones
        apply_stimulus(1, 0, 1, 0, 'h7FFF, 1);
        t0 = tick_cnt; o0 = ones_cnt;
        step(128);
        check_output("max sample first bit", bits[t0], 0);
        check_output("max sample ones", ones_cnt - o0, 63);
        reset_dut();

        // Single buffered sample, then starvation at every boundary
        apply_stimulus(0, 0, 2, 0, 'h1234, 1);
        step(1);
        valid = 1'b0;
        clk_en = 1'b1;
        o0 = ones_cnt; u0 = under_cnt;
        step(20);
        check_output("underrun pulses", under_cnt - u0, 4);
        check_output("underrun ones", ones_cnt - o0, 5);
        reset_dut();

        // Attenuation 1 on 0x7FFE: u = 0xBFFF
        apply_stimulus(1, 0, 1, 1, 'h7FFE, 1);
        t0 = tick_cnt; o0 = ones_cnt;
        step(8192);
        check_output("atten ticks", tick_cnt - t0, 4096);
        check_output("atten ones", ones_cnt - o0, 3071);
        reset_dut();

        // Asynchronous reset with the buffer full, then restart from a boundary
        apply_stimulus(1, 0, 4, 0, 'h5555, 1);
        step(12);
        valid = 1'b0;
        step(3);
        check_output("pre-reset ready", pcm_ready, 0);
        check_output("pre-reset pdm_clk", pdm_clk, 1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async pdm_clk", pdm_clk, 0);
        check_output("async pdm_data", pdm_data, 0);
        check_output("async pcm_ready", pcm_ready, 1);
        check_output("async underrun", underrun, 0);
        step(1);
        sample = '0;
        valid = 1'b1;
        rst = 1'b0;
        t0 = tick_cnt;
        step(40);
        for (int j = 0; j < 4; j++) check_output("restart bit", bits[t0 + j], j % 2);

        i0 = errors;
        $display("[TB] Result: errors=%0d of %0d checks", i0, checks);
        $finish;
      end
    join
  end

endmodule
